// File: rtl/shift_feeder_pkg.sv
// Shared types and defaults for the shift-register feeder.
//  state_e       : feeder FSM states
//  DEF_*         : default WIDTH/DEPTH/GAP/STAGES
//  cnt_w()       : counter width for a value range 0..n-1, never narrower than one bit
package shift_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int unsigned DEF_WIDTH  = 4;
   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned DEF_GAP    = 2;
   localparam int unsigned DEF_STAGES = 4;

   // $clog2(1) is 0, so clamp to one bit for degenerate ranges (e.g. GAP=1).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
//  clock, reset    : clock, synchronous active-high reset
//  enq_i/enq_data_i: write strobe and data (ignored when full)
//  deq_i           : read strobe (ignored when empty); deq_data_o shows the head
//  full_o/empty_o  : occupancy flags derived from the registered count
//  count_o         : current occupancy 0..DEPTH
module sync_fifo
   import shift_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enq_i,
   input  logic [WIDTH-1:0]             enq_data_i,
   input  logic                         deq_i,
   output logic [WIDTH-1:0]             deq_data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = cnt_w(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_enq_c;
   logic             do_deq_c;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign deq_data_o = mem_q[rd_ptr_q];

   assign do_enq_c = enq_i && !full_o;
   assign do_deq_c = deq_i && !empty_o;

   // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_enq_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq_c, do_deq_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock) begin
      if (do_enq_c) mem_q[wr_ptr_q] <= enq_data_i;
   end

endmodule

// File: rtl/shift_stream_feeder.sv
// Paces buffered samples into a shift register as single-cycle shift pulses spaced at
// least GAP cycles apart, and drains the register with STAGES zero shifts on request.
//  clock, reset          : clock, synchronous active-high reset
//  io_in_valid/_ready    : upstream handshake; io_in_bits is the sample
//  io_flush              : one-cycle drain request
//  io_shift, io_out      : registered shift strobe and data to the shift register
//  io_busy               : anything buffered, in flight, or pending
//  io_count              : FIFO occupancy
module shift_stream_feeder
   import shift_feeder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned GAP    = DEF_GAP,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         io_in_valid,
   output logic                         io_in_ready,
   input  logic [WIDTH-1:0]             io_in_bits,
   input  logic                         io_flush,
   output logic                         io_shift,
   output logic [WIDTH-1:0]             io_out,
   output logic                         io_busy,
   output logic [$clog2(DEPTH+1)-1:0]   io_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned GC_W  = cnt_w(GAP);
   localparam int unsigned FC_W  = $clog2(STAGES + 1);

   localparam logic [GC_W-1:0] GC_RELOAD = GC_W'(GAP - 1);
   localparam logic [FC_W-1:0] FC_LOAD   = FC_W'(STAGES);

   state_e           state_q, state_d;
   logic [GC_W-1:0]  gc_q, gc_d;
   logic [FC_W-1:0]  fc_q, fc_d;
   logic             flush_pend_q, flush_pend_d;
   logic             shift_q, shift_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic             enq_c;
   logic             deq_c;
   logic             issue_c;
   logic             gap_ok_c;
   logic             fifo_full_c;
   logic             fifo_empty_c;
   logic [WIDTH-1:0] fifo_head_c;
   logic [CNT_W-1:0] fifo_count_c;

   // Intake is blocked while draining so no sample can slip in between zero shifts.
   assign io_in_ready = !fifo_full_c && (state_q != FLUSH);
   assign enq_c       = io_in_valid && io_in_ready;
   assign gap_ok_c    = (gc_q == '0);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .enq_i      (enq_c),
      .enq_data_i (io_in_bits),
      .deq_i      (deq_c),
      .deq_data_o (fifo_head_c),
      .full_o     (fifo_full_c),
      .empty_o    (fifo_empty_c),
      .count_o    (fifo_count_c)
   );

   // FSM next state, gap/flush counters and output register next values.
   always_comb begin
      state_d      = state_q;
      gc_d         = gap_ok_c ? gc_q : gc_q - GC_W'(1);
      fc_d         = fc_q;
      flush_pend_d = flush_pend_q;
      shift_d      = 1'b0;
      out_d        = out_q;
      deq_c        = 1'b0;
      issue_c      = 1'b0;

      if (io_flush && (state_q != FLUSH)) flush_pend_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (gap_ok_c && !fifo_empty_c) begin
               deq_c   = 1'b1;
               issue_c = 1'b1;
               out_d   = fifo_head_c;
               state_d = RUN;
            end else if (gap_ok_c && flush_pend_q) begin
               // Reached only with the FIFO empty: all earlier samples are out.
               flush_pend_d = 1'b0;
               fc_d         = FC_LOAD;
               state_d      = FLUSH;
            end
         end
         RUN: begin
            if (gap_ok_c) begin
               if (!fifo_empty_c) begin
                  deq_c   = 1'b1;
                  issue_c = 1'b1;
                  out_d   = fifo_head_c;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            if (gap_ok_c) begin
               if (fc_q != '0) begin
                  issue_c = 1'b1;
                  out_d   = '0;
                  fc_d    = fc_q - FC_W'(1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue_c) begin
         shift_d = 1'b1;
         gc_d    = GC_RELOAD;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         gc_q         <= '0;
         fc_q         <= '0;
         flush_pend_q <= 1'b0;
         shift_q      <= 1'b0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         gc_q         <= gc_d;
         fc_q         <= fc_d;
         flush_pend_q <= flush_pend_d;
         shift_q      <= shift_d;
         out_q        <= out_d;
      end
   end

   assign io_shift = shift_q;
   assign io_out   = out_q;
   assign io_count = fifo_count_c;
   assign io_busy  = (state_q != IDLE) || (fifo_count_c != '0) || flush_pend_q;

endmodule

// File: tb/tb_shift_stream_feeder.sv
// Directed bench: three feeder instances (GAP=2, GAP=1, GAP=4), one selected at a time.
module tb_shift_stream_feeder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] bits  = 4'd0;
   logic [1:0] sel   = 2'd0;

   logic       v_in [3];
   logic       f_in [3];
   logic       rdy_v  [3];
   logic       sh_v   [3];
   logic       busy_v [3];
   logic [3:0] out_v  [3];
   logic [2:0] cnt_v  [3];

   logic       rdy, sh, busy;
   logic [3:0] outv;
   logic [2:0] cnt;

   int cyc    = 0;
   int ntot   = 0;
   int nbad   = 0;
   int stalls = 0;
   int pv[$];
   int pc[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_route
      assign v_in[g] = (sel == 2'(g)) ? valid : 1'b0;
      assign f_in[g] = (sel == 2'(g)) ? flush : 1'b0;
   end

   assign rdy  = (sel == 2'd0) ? rdy_v[0]  : (sel == 2'd1) ? rdy_v[1]  : rdy_v[2];
   assign sh   = (sel == 2'd0) ? sh_v[0]   : (sel == 2'd1) ? sh_v[1]   : sh_v[2];
   assign busy = (sel == 2'd0) ? busy_v[0] : (sel == 2'd1) ? busy_v[1] : busy_v[2];
   assign outv = (sel == 2'd0) ? out_v[0]  : (sel == 2'd1) ? out_v[1]  : out_v[2];
   assign cnt  = (sel == 2'd0) ? cnt_v[0]  : (sel == 2'd1) ? cnt_v[1]  : cnt_v[2];

   shift_stream_feeder #(.WIDTH(4), .DEPTH(4), .GAP(2), .STAGES(4)) u_g2 (
      .clock(clock), .reset(reset), .io_in_valid(v_in[0]), .io_in_ready(rdy_v[0]),
      .io_in_bits(bits), .io_flush(f_in[0]), .io_shift(sh_v[0]), .io_out(out_v[0]),
      .io_busy(busy_v[0]), .io_count(cnt_v[0]));

   shift_stream_feeder #(.WIDTH(4), .DEPTH(4), .GAP(1), .STAGES(4)) u_g1 (
      .clock(clock), .reset(reset), .io_in_valid(v_in[1]), .io_in_ready(rdy_v[1]),
      .io_in_bits(bits), .io_flush(f_in[1]), .io_shift(sh_v[1]), .io_out(out_v[1]),
      .io_busy(busy_v[1]), .io_count(cnt_v[1]));

   shift_stream_feeder #(.WIDTH(4), .DEPTH(4), .GAP(4), .STAGES(4)) u_g4 (
      .clock(clock), .reset(reset), .io_in_valid(v_in[2]), .io_in_ready(rdy_v[2]),
      .io_in_bits(bits), .io_flush(f_in[2]), .io_shift(sh_v[2]), .io_out(out_v[2]),
      .io_busy(busy_v[2]), .io_count(cnt_v[2]));

   // Records every shift pulse of the selected instance with its cycle number.
   always @(negedge clock) begin
      if (sh) begin
         pv.push_back(int'(outv));
         pc.push_back(cyc);
      end
   end

   // Advance n cycles; returns just after the falling edge.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         #1;
      end
   endtask

   task automatic clear_rec();
      pv.delete();
      pc.delete();
   endtask

   // Presents one sample and holds it until accepted; acc = edge number of acceptance.
   task automatic send(input logic [3:0] v, output int acc);
      int w;
      w = 0;
      valid = 1'b1;
      bits  = v;
      while (!rdy && w < 50) begin
         step();
         w++;
         stalls++;
      end
      ntot++;
      if (!rdy) begin
         nbad++;
         $display("FAIL send_timeout ready=%b required=1", rdy);
      end
      step();
      acc   = cyc;
      valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      for (int i = 0; i < 3; i++) begin
         sel = 2'(i);
         #1;
         ntot += 5;
         if (sh !== 1'b0)   begin nbad++; $display("FAIL reset_shift[%0d] got=%b exp=0", i, sh); end
         if (outv !== 4'd0) begin nbad++; $display("FAIL reset_out[%0d] got=%h exp=0", i, outv); end
         if (cnt !== 3'd0)  begin nbad++; $display("FAIL reset_count[%0d] got=%0d exp=0", i, cnt); end
         if (busy !== 1'b0) begin nbad++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy); end
         if (rdy !== 1'b1)  begin nbad++; $display("FAIL reset_ready[%0d] got=%b exp=1", i, rdy); end
      end
      reset = 1'b0;
      sel   = 2'd0;
      step(2);
      ntot += 2;
      if (rdy !== 1'b1)  begin nbad++; $display("FAIL post_reset_ready got=%b exp=1", rdy); end
      if (busy !== 1'b0) begin nbad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single();
      int k;
      sel = 2'd0;
      clear_rec();
      send(4'hA, k);
      ntot += 2;
      if (cnt !== 3'd1) begin nbad++; $display("FAIL single_count_acc got=%0d exp=1", cnt); end
      if (sh !== 1'b0)  begin nbad++; $display("FAIL single_early_shift got=%b exp=0", sh); end
      step();
      ntot += 3;
      if (sh !== 1'b1)   begin nbad++; $display("FAIL single_shift got=%b exp=1", sh); end
      if (outv !== 4'hA) begin nbad++; $display("FAIL single_out got=%h exp=a", outv); end
      if (cnt !== 3'd0)  begin nbad++; $display("FAIL single_count_deq got=%0d exp=0", cnt); end
      step(4);
      ntot += 3;
      if (busy !== 1'b0)   begin nbad++; $display("FAIL single_busy got=%b exp=0", busy); end
      if (pv.size() != 1)  begin nbad++; $display("FAIL single_pulses got=%0d exp=1", pv.size()); end
      else if (pc[0] != k + 1) begin nbad++; $display("FAIL single_latency got=%0d exp=%0d", pc[0], k + 1); end
   endtask

   task automatic test_burst();
      int k0, k;
      sel = 2'd0;
      clear_rec();
      send(4'd1, k0);
      for (int i = 2; i <= 5; i++) send(4'(i), k);
      step(15);
      ntot++;
      if (pv.size() != 5) begin
         nbad++; $display("FAIL burst_pulses got=%0d exp=5", pv.size());
      end else begin
         ntot++;
         if (pc[0] != k0 + 1) begin nbad++; $display("FAIL burst_first got=%0d exp=%0d", pc[0], k0 + 1); end
         for (int i = 0; i < 5; i++) begin
            ntot++;
            if (pv[i] != i + 1) begin nbad++; $display("FAIL burst_val[%0d] got=%0d exp=%0d", i, pv[i], i + 1); end
            if (i > 0) begin
               ntot++;
               if (pc[i] - pc[i-1] != 2) begin nbad++; $display("FAIL burst_gap[%0d] got=%0d exp=2", i, pc[i] - pc[i-1]); end
            end
         end
      end
   endtask

   task automatic test_full();
      int k;
      sel = 2'd2;
      clear_rec();
      stalls = 0;
      for (int i = 1; i <= 6; i++) send(4'(i), k);
      ntot += 2;
      if (stalls != 1)  begin nbad++; $display("FAIL full_stalls got=%0d exp=1", stalls); end
      if (cnt !== 3'd4) begin nbad++; $display("FAIL full_count got=%0d exp=4", cnt); end
      ntot++;
      if (rdy !== 1'b0) begin nbad++; $display("FAIL full_ready got=%b exp=0", rdy); end
      step(30);
      ntot++;
      if (pv.size() != 6) begin
         nbad++; $display("FAIL full_pulses got=%0d exp=6", pv.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            ntot++;
            if (pv[i] != i + 1) begin nbad++; $display("FAIL full_val[%0d] got=%0d exp=%0d", i, pv[i], i + 1); end
            if (i > 0) begin
               ntot++;
               if (pc[i] - pc[i-1] != 4) begin nbad++; $display("FAIL full_gap[%0d] got=%0d exp=4", i, pc[i] - pc[i-1]); end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int k0, k;
      sel = 2'd1;
      clear_rec();
      send(4'd7, k0);
      send(4'd8, k);
      send(4'd9, k);
      step(6);
      ntot++;
      if (pv.size() != 3) begin
         nbad++; $display("FAIL b2b_pulses got=%0d exp=3", pv.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            ntot += 2;
            if (pv[i] != 7 + i)      begin nbad++; $display("FAIL b2b_val[%0d] got=%0d exp=%0d", i, pv[i], 7 + i); end
            if (pc[i] != k0 + 1 + i) begin nbad++; $display("FAIL b2b_cyc[%0d] got=%0d exp=%0d", i, pc[i], k0 + 1 + i); end
         end
      end
   endtask

   task automatic test_flush();
      int k, rl, bl;
      int exp_v[6] = '{5, 6, 0, 0, 0, 0};
      sel = 2'd0;
      clear_rec();
      send(4'd5, k);
      send(4'd6, k);
      flush = 1'b1;
      step();
      flush = 1'b0;
      rl = 0;
      bl = -1;
      for (int i = 0; i < 25; i++) begin
         step();
         if (!rdy) rl++;
         if (!busy && bl < 0) bl = cyc;
      end
      ntot++;
      if (pv.size() != 6) begin
         nbad++; $display("FAIL flush_pulses got=%0d exp=6", pv.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            ntot++;
            if (pv[i] != exp_v[i]) begin nbad++; $display("FAIL flush_val[%0d] got=%0d exp=%0d", i, pv[i], exp_v[i]); end
         end
         ntot += 2;
         if (pc[1] - pc[0] != 2) begin nbad++; $display("FAIL flush_gap_data got=%0d exp=2", pc[1] - pc[0]); end
         if (pc[2] - pc[1] < 2)  begin nbad++; $display("FAIL flush_gap_edge got=%0d exp>=2", pc[2] - pc[1]); end
         for (int i = 3; i < 6; i++) begin
            ntot++;
            if (pc[i] - pc[i-1] != 2) begin nbad++; $display("FAIL flush_gap_zero[%0d] got=%0d exp=2", i, pc[i] - pc[i-1]); end
         end
         ntot++;
         if (bl != pc[5] + 2) begin nbad++; $display("FAIL flush_busy_drop got=%0d exp=%0d", bl, pc[5] + 2); end
      end
      ntot++;
      if (rl != 9) begin nbad++; $display("FAIL flush_ready_low got=%0d exp=9", rl); end
   endtask

   task automatic test_reset_mid();
      int k;
      sel = 2'd2;
      clear_rec();
      for (int i = 1; i <= 4; i++) send(4'(i), k);
      ntot++;
      if (cnt !== 3'd3) begin nbad++; $display("FAIL mid_count_before got=%0d exp=3", cnt); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      ntot += 4;
      if (sh !== 1'b0)   begin nbad++; $display("FAIL mid_shift got=%b exp=0", sh); end
      if (cnt !== 3'd0)  begin nbad++; $display("FAIL mid_count got=%0d exp=0", cnt); end
      if (rdy !== 1'b1)  begin nbad++; $display("FAIL mid_ready got=%b exp=1", rdy); end
      if (busy !== 1'b0) begin nbad++; $display("FAIL mid_busy got=%b exp=0", busy); end
      step(20);
      ntot++;
      if (pv.size() != 1) begin nbad++; $display("FAIL mid_stale_pulses got=%0d exp=1", pv.size()); end
      else begin
         ntot++;
         if (pv[0] != 1) begin nbad++; $display("FAIL mid_first_val got=%0d exp=1", pv[0]); end
      end
   endtask

   task automatic test_idle_flush();
      sel = 2'd0;
      clear_rec();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step(2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step(20);
      ntot += 2;
      if (pv.size() != 4) begin nbad++; $display("FAIL idle_flush_pulses got=%0d exp=4", pv.size()); end
      if (busy !== 1'b0)  begin nbad++; $display("FAIL idle_flush_busy got=%b exp=0", busy); end
      for (int i = 0; i < pv.size(); i++) begin
         ntot++;
         if (pv[i] != 0) begin nbad++; $display("FAIL idle_flush_val[%0d] got=%0d exp=0", i, pv[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_idle_flush();
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
